// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit/receive blocks: register map,
// parity encodings and the frame state machine states.
package spart_pkg;

    // Processor I/O register addresses
    localparam logic [1:0] SPART_TXDATA = 2'b00;
    localparam logic [1:0] SPART_CTRL   = 2'b01;
    localparam logic [1:0] SPART_DIVLO  = 2'b10;
    localparam logic [1:0] SPART_DIVHI  = 2'b11;

    // Parity select encodings (11 behaves like 00)
    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    // Frame state machine states, common to transmitter and receiver
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } spart_state_e;

    // True when the parity select calls for a parity bit
    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

    // Parity bit from the XOR of the data bits and the parity select
    function automatic logic par_bit(input logic data_xor, input logic [1:0] par);
        return data_xor ^ (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Synchronous FIFO with wrapping pointers, occupancy count and full/empty
// flags. A push while full is accepted only when a pop happens in the same
// cycle. A pop while empty is ignored.
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_MAX);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Storage, pointers and occupancy count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: bus register decode, baud divisor, character format
// control, transmit FIFO and the frame serialiser driving txd.
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       txd,
    output logic       tbr,
    output logic       tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 wr_s;
    logic                 status_rd_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_head_s;
    logic [CW-1:0]        fifo_count_s;
    logic [3:0]           count_sat_s;

    logic [15:0]          div_q;
    logic [1:0]           par_q;
    logic                 stop2_q;
    logic                 ovf_q;

    spart_state_e         state_q;
    logic [15:0]          baud_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop_more_q;
    logic                 txd_q;

    assign wr_s        = iocs && !iorw;
    assign status_rd_s = iocs && iorw && (ioaddr == SPART_CTRL);
    assign push_s      = wr_s && (ioaddr == SPART_TXDATA);
    assign bit_end_s   = (baud_q == 16'd0);
    // Take the next character when idle, or when the last stop bit ends
    assign pop_s       = !fifo_empty_s &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_STOP) && bit_end_s && !stop_more_q));

    assign tbr     = !fifo_full_s;
    assign tx_idle = fifo_empty_s && (state_q == ST_IDLE);
    assign txd     = txd_q;

    spart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wdata[DATA_BITS-1:0]),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Saturate the FIFO count to the 4-bit status field
    always_comb begin
        if (32'(fifo_count_s) > 32'd15) begin
            count_sat_s = 4'hF;
        end else begin
            count_sat_s = 4'(fifo_count_s);
        end
    end

    // Read data mux, purely a function of the address
    always_comb begin
        case (ioaddr)
            SPART_TXDATA: rdata = 8'h00;
            SPART_CTRL:   rdata = {count_sat_s, 1'b0, ovf_q, tx_idle, tbr};
            SPART_DIVLO:  rdata = div_q[7:0];
            SPART_DIVHI:  rdata = div_q[15:8];
            default:      rdata = 8'h00;
        endcase
    end

    // Control, divisor and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DIV_RESET;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_s) begin
                case (ioaddr)
                    SPART_CTRL: begin
                        par_q   <= wdata[1:0];
                        stop2_q <= wdata[2];
                    end
                    SPART_DIVLO: div_q[7:0]  <= wdata;
                    SPART_DIVHI: div_q[15:8] <= wdata;
                    default:     div_q       <= div_q;
                endcase
            end
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_q <= 1'b1;
            end else if (status_rd_s) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Frame FSM: baud counter, shift register and registered txd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            baud_q      <= 16'd0;
            shift_q     <= '0;
            bit_idx_q   <= 3'd0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_more_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_q     <= fifo_head_s;
                        par_en_q    <= par_enabled(par_q);
                        par_bit_q   <= par_bit(^fifo_head_s, par_q);
                        stop_more_q <= stop2_q;
                        baud_q      <= div_q;
                        txd_q       <= 1'b0;
                        state_q     <= ST_START;
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_q    <= div_q;
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_q <= div_q;
                        if (bit_idx_q == LAST_BIT) begin
                            if (par_en_q) begin
                                txd_q   <= par_bit_q;
                                state_q <= ST_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        baud_q  <= div_q;
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_q <= div_q;
                        if (stop_more_q) begin
                            stop_more_q <= 1'b0;
                            txd_q       <= 1'b1;
                        end else if (pop_s) begin
                            shift_q     <= fifo_head_s;
                            par_en_q    <= par_enabled(par_q);
                            par_bit_q   <= par_bit(^fifo_head_s, par_q);
                            stop_more_q <= stop2_q;
                            txd_q       <= 1'b0;
                            state_q     <= ST_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Bench for spart_tx_fifo: register table, directed frame sequences and a
// random bus stream, all compared every cycle against a queue-based model of
// the serial line.
module tb_spart_tx_fifo;
    import spart_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata8, rdata5;
    logic       txd8, tbr8, idle8, txd5, tbr5, idle5;

    always #5 clk = ~clk;

    spart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd5)) dut8 (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .wdata(wdata), .rdata(rdata8), .txd(txd8), .tbr(tbr8), .tx_idle(idle8));

    spart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd5)) dut5 (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .wdata(wdata), .rdata(rdata5), .txd(txd5), .tbr(tbr5), .tx_idle(idle5));

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model of the 8-bit instance ----------------
    logic [7:0]  m_q[$];     // characters waiting in the FIFO
    logic        m_wave[$];  // txd values for the cycles still to come
    logic [15:0] m_div;
    logic [1:0]  m_par;
    logic        m_stop2, m_ovf, m_txd, m_tbr, m_idle;

    function automatic void model_reset();
        m_q.delete(); m_wave.delete();
        m_div = 16'd5; m_par = 2'b00; m_stop2 = 1'b0; m_ovf = 1'b0;
        m_txd = 1'b1; m_tbr = 1'b1; m_idle = 1'b1;
    endfunction

    // Whole frame for one character as a per-cycle txd waveform
    function automatic void append_frame(input logic [7:0] ch);
        logic bits[$];
        int ones = $countones(ch);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(ch[i]);
        if (m_par == 2'b01) bits.push_back(ones % 2 == 1);
        if (m_par == 2'b10) bits.push_back(ones % 2 == 0);
        bits.push_back(1'b1);
        if (m_stop2) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int r = 0; r <= int'(m_div); r++) m_wave.push_back(bits[b]);
        end
    endfunction

    // Advance the model across one rising edge using the bus values now driven
    function automatic void model_edge();
        logic busy;
        if (m_wave.size() == 0 && m_q.size() != 0) append_frame(m_q.pop_front());
        if (m_wave.size() != 0) begin m_txd = m_wave.pop_front(); busy = 1'b1; end
        else begin m_txd = 1'b1; busy = 1'b0; end
        if (iocs && !iorw) begin
            case (ioaddr)
                SPART_TXDATA: if (m_q.size() < DEPTH) m_q.push_back(wdata); else m_ovf = 1'b1;
                SPART_CTRL:   begin m_par = wdata[1:0]; m_stop2 = wdata[2]; end
                SPART_DIVLO:  m_div[7:0] = wdata;
                default:      m_div[15:8] = wdata;
            endcase
        end else if (iocs && iorw && ioaddr == SPART_CTRL) begin
            m_ovf = 1'b0;
        end
        m_tbr  = (m_q.size() < DEPTH);
        m_idle = !busy && (m_q.size() == 0);
    endfunction

    function automatic logic [7:0] exp_rdata(input logic [1:0] a);
        logic [3:0] c;
        c = (m_q.size() > 15) ? 4'd15 : 4'(m_q.size());
        case (a)
            SPART_CTRL:  return {c, 1'b0, m_ovf, m_idle, m_tbr};
            SPART_DIVLO: return m_div[7:0];
            SPART_DIVHI: return m_div[15:8];
            default:     return 8'h00;
        endcase
    endfunction

    // ---------------- bus helpers ----------------
    task automatic tick();
        if (rst_n) model_edge();
        @(negedge clk);
        chk("txd/tbr/tx_idle", {txd8, tbr8, idle8}, {m_txd, m_tbr, m_idle});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = d;
        tick();
        iocs = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        v = rdata8;
        chk($sformatf("rdata@%0d", a), rdata8, exp_rdata(a));
        tick();
        iocs = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        iocs = 1'b0;
        while (!m_idle && k < 3000) begin tick(); k++; end
        tick();
        chk({name, " drain"}, (k < 3000), 1'b1);
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic [8:1] exp_txd5;
        logic [8:1] exp_idle5;
        logic       tbr_log[6];
        int n;

        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset values and register read-back
        tbl[0]  = '{1'b0, SPART_CTRL,   8'h00, 8'h03};
        tbl[1]  = '{1'b0, SPART_DIVLO,  8'h00, 8'h05};
        tbl[2]  = '{1'b0, SPART_DIVHI,  8'h00, 8'h00};
        tbl[3]  = '{1'b0, SPART_TXDATA, 8'h00, 8'h00};
        tbl[4]  = '{1'b1, SPART_DIVLO,  8'h34, 8'h00};
        tbl[5]  = '{1'b1, SPART_DIVHI,  8'h12, 8'h00};
        tbl[6]  = '{1'b0, SPART_DIVLO,  8'h00, 8'h34};
        tbl[7]  = '{1'b0, SPART_DIVHI,  8'h00, 8'h12};
        tbl[8]  = '{1'b1, SPART_DIVHI,  8'h00, 8'h00};
        tbl[9]  = '{1'b1, SPART_DIVLO,  8'h05, 8'h00};
        tbl[10] = '{1'b0, SPART_CTRL,   8'h00, 8'h03};
        chk("reset txd", txd8, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wd);
            else begin
                bus_read(tbl[i].addr, v);
                chk($sformatf("vec%0d", i), v, tbl[i].exp);
            end
        end

        // Default format, div=5: 0x6A
        bus_write(SPART_TXDATA, 8'h6A);
        chk("A before start", txd8, 1'b1);
        tick();
        chk("A start bit", txd8, 1'b0);
        n = 0;
        while (!idle8 && n < 200) begin tick(); n++; end
        chk("A frame cycles", n, 60);

        // Even parity, div=0
        bus_write(SPART_DIVLO, 8'h00);
        bus_write(SPART_CTRL, 8'h01);
        bus_write(SPART_TXDATA, 8'hF3);
        repeat (10) tick();
        chk("B even parity", txd8, 1'b0);
        wait_idle("B even");

        // Odd parity, two stop bits, two frames
        bus_write(SPART_CTRL, 8'h06);
        bus_write(SPART_TXDATA, 8'hF3);
        bus_write(SPART_TXDATA, 8'hF3);
        repeat (9) tick();
        chk("B odd parity", txd8, 1'b1);
        tick(); chk("B stop1", txd8, 1'b1);
        tick(); chk("B stop2", txd8, 1'b1);
        tick(); chk("B next start", txd8, 1'b0);
        wait_idle("B odd");

        // Burst of DEPTH+2 writes: last one dropped
        bus_write(SPART_CTRL, 8'h00);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus_write(SPART_TXDATA, 8'(8'h11 * (i + 1)));
            tbr_log[i] = tbr8;
        end
        chk("burst tbr after 4th", tbr_log[3], 1'b1);
        chk("burst tbr after 5th", tbr_log[4], 1'b0);
        bus_read(SPART_CTRL, v);
        chk("burst status ovf", v, 8'h44);
        bus_read(SPART_CTRL, v);
        chk("burst status cleared", v, 8'h40);
        wait_idle("burst");

        // Write while full on the same edge as an end-of-frame pop
        for (int i = 0; i < DEPTH + 1; i++) bus_write(SPART_TXDATA, 8'($urandom));
        repeat (6) tick();
        bus_write(SPART_TXDATA, 8'hC5);
        bus_read(SPART_CTRL, v);
        chk("full+pop status", v, 8'h40);
        wait_idle("full+pop");
        bus_read(SPART_CTRL, v);
        chk("full+pop final", v, 8'h03);

        // 5-bit character on the second instance
        rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
        bus_write(SPART_DIVLO, 8'h00);
        bus_write(SPART_TXDATA, 8'hFF);
        chk("5bit pre", txd5, 1'b1);
        exp_txd5  = 8'b1111_1110;
        exp_idle5 = 8'b1000_0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("5bit txd k%0d", k), txd5, exp_txd5[k]);
            chk($sformatf("5bit idle k%0d", k), idle5, exp_idle5[k]);
        end
        chk("5bit tbr", tbr5, 1'b1);
        wait_idle("5bit");

        // Reset in the middle of DATA
        bus_write(SPART_DIVLO, 8'h02);
        bus_write(SPART_TXDATA, 8'h00);
        repeat (6) tick();
        chk("pre-reset busy", {txd8, idle8}, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("rst txd", txd8, 1'b1);
        chk("rst tbr", tbr8, 1'b1);
        chk("rst tx_idle", idle8, 1'b1);
        ioaddr = SPART_CTRL;  #1 chk("rst status", rdata8, 8'h03);
        ioaddr = SPART_DIVLO; #1 chk("rst divlo", rdata8, 8'h05);
        chk("rst divlo 5bit", rdata5, 8'h05);
        model_reset();
        tick();
        rst_n = 1'b1;

        // Random bus traffic against the model
        bus_write(SPART_DIVLO, 8'h01);
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: bus_write(SPART_TXDATA, 8'($urandom));
                5: bus_write(SPART_CTRL, 8'($urandom_range(0, 7)));
                6: bus_read(SPART_CTRL, v);
                7: if (m_idle) bus_write(SPART_DIVLO, 8'($urandom_range(0, 2)));
                   else tick();
                8: bus_read(2'($urandom_range(0, 3)), v);
                default: begin
                    iocs = 1'b0;
                    repeat ($urandom_range(1, 4)) tick();
                end
            endcase
        end
        wait_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
